// File: rtl/display_mux_seq.sv
// Registered N-source selector for the OLED pixel stream and 7-segment display,
// with frame-synchronised blanking on source change. Define DISP_MUX_FADE_EN to dim the old source instead of blanking.
module display_mux_seq #(
  parameter int              N_SRC        = 8,
  parameter int              SEL_W        = 4,
  parameter int              PIX_W        = 16,
  parameter int              BLANK_FRAMES = 2,
  parameter logic [15:0]     SEG_MASK     = 16'h0007,
  parameter logic [PIX_W-1:0] BLANK_PIX   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       state,
  input  logic                   frame_begin,
  input  logic [N_SRC*PIX_W-1:0] oled_in,
  input  logic [N_SRC*4-1:0]     an_in,
  input  logic [N_SRC*8-1:0]     seg_in,
  output logic [PIX_W-1:0]       oled_data,
  output logic [3:0]             an,
  output logic [7:0]             seg,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   busy,
  output logic                   switch_done
);

  typedef enum logic [0:0] {SHOW, BLANK} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [SEL_W-1:0] active_sel_q, active_sel_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [3:0]       frame_cnt_q, frame_cnt_d;
  logic [PIX_W-1:0] oled_q, oled_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             busy_q, busy_d;
  logic             switch_done_q, switch_done_d;

  logic [PIX_W-1:0] chan_pix;
  logic [3:0]       chan_an;
  logic [7:0]       chan_seg;
  logic             chan_pass;
  logic             state_valid;

`ifdef DISP_MUX_FADE_EN
  // RGB565 only: each colour field shifts right by min(cnt+1, 6).
  function automatic logic [15:0] dim565(input logic [15:0] px, input logic [3:0] cnt);
    logic [2:0] sh;
    sh = (cnt >= 4'd5) ? 3'd6 : 3'(cnt + 4'd1);
    return {px[15:11] >> sh, px[10:5] >> sh, px[4:0] >> sh};
  endfunction
`endif

  always_comb begin
    chan_pix  = '0;
    chan_an   = 4'hF;
    chan_seg  = 8'hFF;
    chan_pass = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (active_sel_q == SEL_W'(i)) begin
        chan_pix  = oled_in[i*PIX_W +: PIX_W];
        chan_an   = an_in[i*4 +: 4];
        chan_seg  = seg_in[i*8 +: 8];
        chan_pass = SEG_MASK[i];
      end
    end
  end

  assign state_valid = (int'(state) < N_SRC);

  always_comb begin
    fsm_d         = fsm_q;
    active_sel_d  = active_sel_q;
    target_d      = target_q;
    frame_cnt_d   = frame_cnt_q;
    busy_d        = busy_q;
    switch_done_d = 1'b0;
    oled_d        = chan_pix;
    an_d          = 4'hF;
    seg_d         = 8'hFF;
    case (fsm_q)
      SHOW: begin
        if (chan_pass) begin
          an_d  = chan_an;
          seg_d = chan_seg;
        end
        if (state_valid && state != active_sel_q) begin
          if (BLANK_FRAMES == 0) begin
            active_sel_d  = state;
            switch_done_d = 1'b1;
          end else begin
            target_d    = state;
            frame_cnt_d = 4'd0;
            busy_d      = 1'b1;
            fsm_d       = BLANK;
          end
        end
      end
      BLANK: begin
`ifdef DISP_MUX_FADE_EN
        oled_d = PIX_W'(dim565(16'(chan_pix), frame_cnt_q));
`else
        oled_d = BLANK_PIX;
`endif
        // A retarget restarts the blank even if a frame boundary arrives together.
        if (state_valid && state != target_q) begin
          target_d    = state;
          frame_cnt_d = 4'd0;
        end else if (frame_begin) begin
          if (frame_cnt_q == 4'(BLANK_FRAMES - 1)) begin
            active_sel_d  = target_q;
            busy_d        = 1'b0;
            switch_done_d = 1'b1;
            frame_cnt_d   = 4'd0;
            fsm_d         = SHOW;
          end else begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end
        end
      end
      default: fsm_d = SHOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q         <= SHOW;
      active_sel_q  <= '0;
      target_q      <= '0;
      frame_cnt_q   <= 4'd0;
      oled_q        <= '0;
      an_q          <= 4'hF;
      seg_q         <= 8'hFF;
      busy_q        <= 1'b0;
      switch_done_q <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      active_sel_q  <= active_sel_d;
      target_q      <= target_d;
      frame_cnt_q   <= frame_cnt_d;
      oled_q        <= oled_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      busy_q        <= busy_d;
      switch_done_q <= switch_done_d;
    end
  end

  assign oled_data   = oled_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign active_sel  = active_sel_q;
  assign busy        = busy_q;
  assign switch_done = switch_done_q;

endmodule

// File: tb/tb_display_mux_seq.sv
// Scoreboard bench for display_mux_seq: a transaction model pushes expected outputs
// per driven cycle, and they are popped and compared one cycle later.
module tb_display_mux_seq;

  localparam int          N_SRC = 8;
  localparam int          SEL_W = 4;
  localparam int          PIX_W = 16;
  localparam int          BF    = 2;
  localparam logic [15:0] MASK  = 16'h0007;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [SEL_W-1:0]       state;
  logic                   frame_begin;
  logic [N_SRC*PIX_W-1:0] oled_in;
  logic [N_SRC*4-1:0]     an_in;
  logic [N_SRC*8-1:0]     seg_in;
  logic [PIX_W-1:0]       oled_data;
  logic [3:0]             an;
  logic [7:0]             seg;
  logic [SEL_W-1:0]       active_sel;
  logic                   busy;
  logic                   switch_done;

  display_mux_seq #(
    .N_SRC(N_SRC), .SEL_W(SEL_W), .PIX_W(PIX_W), .BLANK_FRAMES(BF),
    .SEG_MASK(MASK), .BLANK_PIX(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .frame_begin(frame_begin),
    .oled_in(oled_in), .an_in(an_in), .seg_in(seg_in),
    .oled_data(oled_data), .an(an), .seg(seg), .active_sel(active_sel),
    .busy(busy), .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] oled;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  bit          churn = 0;
  logic [15:0] pix[N_SRC];
  logic [3:0]  anv[N_SRC];
  logic [7:0]  segv[N_SRC];

  bit          m_show = 1;
  int          m_active = 0;
  int          m_target = 0;
  int          m_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] blankPix(input logic [15:0] px, input int cnt);
`ifdef DISP_MUX_FADE_EN
    int s, r, g, b;
    s = (cnt + 1 > 6) ? 6 : cnt + 1;
    r = int'(px[15:11]) / (1 << s);
    g = int'(px[10:5]) / (1 << s);
    b = int'(px[4:0]) / (1 << s);
    return {5'(r), 6'(g), 5'(b)};
`else
    return (px & 16'h0000) | 16'h0000;
`endif
  endfunction

  task automatic applyStimulus(input logic rn, input logic [3:0] st, input logic fb);
    exp_t e;
    exp_t got;
    bit   valid;
    rst_n = rn;
    state = st;
    frame_begin = fb;
    for (int i = 0; i < N_SRC; i++) begin
      if (churn) pix[i] = 16'($urandom);
      oled_in[i*16 +: 16] = pix[i];
      an_in[i*4 +: 4]     = anv[i];
      seg_in[i*8 +: 8]    = segv[i];
    end
    e.done = 1'b0;
    if (!rn) begin
      e.oled = 16'h0000; e.an = 4'hF; e.seg = 8'hFF;
      m_show = 1; m_active = 0; m_target = 0; m_cnt = 0;
    end else begin
      valid = (int'(st) < N_SRC);
      if (m_show) begin
        e.oled = pix[m_active];
        e.an   = MASK[m_active] ? anv[m_active]  : 4'hF;
        e.seg  = MASK[m_active] ? segv[m_active] : 8'hFF;
        if (valid && int'(st) != m_active) begin
          m_target = int'(st); m_cnt = 0; m_show = 0;
        end
      end else begin
        e.oled = blankPix(pix[m_active], m_cnt);
        e.an = 4'hF; e.seg = 8'hFF;
        if (valid && int'(st) != m_target) begin
          m_target = int'(st); m_cnt = 0;
        end else if (fb) begin
          m_cnt++;
          if (m_cnt == BF) begin
            m_active = m_target; m_show = 1; m_cnt = 0; e.done = 1'b1;
          end
        end
      end
    end
    e.sel  = 4'(m_active);
    e.busy = !m_show;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (switch_done) done_seen++;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      checkOutput("oled_data",   32'(oled_data),   32'(got.oled));
      checkOutput("an",          32'(an),          32'(got.an));
      checkOutput("seg",         32'(seg),         32'(got.seg));
      checkOutput("active_sel",  32'(active_sel),  32'(got.sel));
      checkOutput("busy",        32'(busy),        32'(got.busy));
      checkOutput("switch_done", 32'(switch_done), 32'(got.done));
    end
  endtask

  // Holds a state for n cycles with a frame pulse every `period` cycles.
  task automatic runFrames(input logic [3:0] st, input int n, input int period);
    for (int c = 0; c < n; c++) applyStimulus(1'b1, st, (c % period) == (period - 1));
  endtask

  initial begin
    for (int i = 0; i < N_SRC; i++) begin
      pix[i] = 16'h1000 + 16'(i); anv[i] = 4'h0 + 4'(i); segv[i] = 8'h80 + 8'(i);
    end
    rst_n = 1'b0; state = 4'd3; frame_begin = 1'b0;
    oled_in = '0; an_in = '0; seg_in = '0;

    applyStimulus(1'b0, 4'd3, 1'b0);
    applyStimulus(1'b0, 4'd3, 1'b0);
    checkOutput("reset_oled", 32'(oled_data), 32'h0000);
    checkOutput("reset_sel", 32'(active_sel), 32'd0);

    // Basic switch 0 -> 2, frame pulses at cycles 10 and 20.
    pix[2] = 16'hF800; pix[0] = 16'h1234; done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      applyStimulus(1'b1, (c >= 1) ? 4'd2 : 4'd0, (c == 10) || (c == 20));
      if (c == 5)  checkOutput("busy_mid_switch", 32'(busy), 32'd1);
      if (c == 15) checkOutput("blank_mid_switch", 32'(oled_data), 32'(blankPix(16'h1234, 1)));
      if (c == 21) checkOutput("new_pixel", 32'(oled_data), 32'hF800);
    end
    checkOutput("switch_sel", 32'(active_sel), 32'd2);
    checkOutput("switch_once", 32'(done_seen), 32'd1);

    churn = 1;
    segv[5] = 8'h12;
    runFrames(4'd5, 16, 5);
    checkOutput("mask_seg5", 32'(seg), 32'hFF);
    checkOutput("mask_an5", 32'(an), 32'hF);

    anv[1] = 4'hE; segv[1] = 8'hC0;
    runFrames(4'd1, 16, 5);
    checkOutput("pass_an1", 32'(an), 32'hE);
    checkOutput("pass_seg1", 32'(seg), 32'hC0);

    runFrames(4'd9, 12, 3);
    checkOutput("invalid_sel", 32'(active_sel), 32'd1);
    checkOutput("invalid_busy", 32'(busy), 32'd0);

    // Retarget 2 -> 4; the retarget coincides with a frame pulse.
    done_seen = 0;
    for (int c = 0; c < 16; c++)
      applyStimulus(1'b1, (c >= 5) ? 4'd4 : 4'd2, (c == 3) || (c == 5) || (c == 8) || (c == 12));
    checkOutput("retarget_sel", 32'(active_sel), 32'd4);
    checkOutput("retarget_once", 32'(done_seen), 32'd1);

    // Invalid state during blank is ignored; transition still lands on 6.
    for (int c = 0; c < 14; c++)
      applyStimulus(1'b1, (c >= 2 && c < 10) ? 4'd12 : 4'd6, (c % 4) == 3);
    checkOutput("blank_invalid_sel", 32'(active_sel), 32'd6);

    // Reset in the middle of a blank abandons it.
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 4'd3, c == 3);
    applyStimulus(1'b0, 4'd3, 1'b0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    runFrames(4'd0, 4, 10);

    // Retarget back to the shown source still completes with a pulse.
    done_seen = 0;
    for (int c = 0; c < 14; c++) applyStimulus(1'b1, (c >= 3) ? 4'd0 : 4'd7, (c % 4) == 2);
    checkOutput("back_sel", 32'(active_sel), 32'd0);
    checkOutput("back_once", 32'(done_seen), 32'd1);

    // Blank pixels derived from an all-ones old source.
    churn = 0; pix[0] = 16'hFFFF; pix[3] = 16'h5A5A;
    applyStimulus(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'd3, 1'b0);
    applyStimulus(1'b1, 4'd3, 1'b0);
`ifdef DISP_MUX_FADE_EN
    checkOutput("fade_frame0", 32'(oled_data), 32'h7BEF);
`else
    checkOutput("blank_frame0", 32'(oled_data), 32'h0000);
`endif
    applyStimulus(1'b1, 4'd3, 1'b1);
    applyStimulus(1'b1, 4'd3, 1'b0);
`ifdef DISP_MUX_FADE_EN
    checkOutput("fade_frame1", 32'(oled_data), 32'h39E7);
`else
    checkOutput("blank_frame1", 32'(oled_data), 32'h0000);
`endif
    applyStimulus(1'b1, 4'd3, 1'b1);
    applyStimulus(1'b1, 4'd3, 1'b0);
    checkOutput("after_blank", 32'(oled_data), 32'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
